// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receive-side VGA timing monitor.
// Registers hs/vs/de/RGB once, measures line and frame timing, compares
// against the expected mode, declares lock after LOCK_FRAMES good frames
// and counts failed frames seen while locked.
// Optional feature: define VGA_RX_CHECKSUM_EN to build the 32-bit frame pixel
// checksum on frame_sum_o; otherwise frame_sum_o is tied to zero.
module vga_rx_monitor #(
  parameter int PIX_WIDTH   = 12,
  parameter int H_DISP      = 1280,
  parameter int H_TOTAL     = 1688,
  parameter int V_DISP      = 1024,
  parameter int V_TOTAL     = 1066,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 vga_hs_i,
  input  logic                 vga_vs_i,
  input  logic                 vga_de_i,
  input  logic [7:0]           vga_r_i,
  input  logic [7:0]           vga_g_i,
  input  logic [7:0]           vga_b_i,
  output logic [PIX_WIDTH-1:0] meas_h_total_o,
  output logic [PIX_WIDTH-1:0] meas_h_active_o,
  output logic [PIX_WIDTH-1:0] meas_v_total_o,
  output logic [PIX_WIDTH-1:0] meas_v_active_o,
  output logic                 frame_done_o,
  output logic                 frame_ok_o,
  output logic                 locked_o,
  output logic [7:0]           err_cnt_o,
  output logic [31:0]          frame_sum_o
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic                 HS_ACT    = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic                 VS_ACT    = (VS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [PIX_WIDTH-1:0] ZERO_C    = {PIX_WIDTH{1'b0}};
  localparam logic [PIX_WIDTH-1:0] H_DISP_C  = PIX_WIDTH'(H_DISP);
  localparam logic [PIX_WIDTH-1:0] H_TOTAL_C = PIX_WIDTH'(H_TOTAL);
  localparam logic [PIX_WIDTH-1:0] V_DISP_C  = PIX_WIDTH'(V_DISP);
  localparam logic [PIX_WIDTH-1:0] V_TOTAL_C = PIX_WIDTH'(V_TOTAL);
  localparam logic [3:0]           LOCK_C    = 4'(LOCK_FRAMES);

  // Saturating increment shared by all timing counters.
  function automatic logic [PIX_WIDTH-1:0] sat_inc(input logic [PIX_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + PIX_WIDTH'(1);
    end
  endfunction

  logic                 hs_r, vs_r, de_r, hs_d_r, vs_d_r;
  logic                 hs_lead_s, vs_lead_s, line_evt_s;
  logic [PIX_WIDTH-1:0] h_cnt_r, de_cnt_r, line_cnt_r, act_cnt_r;
  logic [PIX_WIDTH-1:0] h_total_s, line_cnt_upd_s, act_cnt_upd_s;
  logic                 line_bad_s, line_err_set_s, line_err_r, skip_r;
  logic                 pend_r, pend_lerr_r;
  logic [PIX_WIDTH-1:0] pend_vtot_r, pend_vact_r;
  state_t               state_r, state_nxt_s;
  logic                 frame_ok_s, enter_meas_s;
  logic [3:0]           match_cnt_r, match_nxt_s, match_inc_s;
  logic [7:0]           err_nxt_s;
  logic                 done_nxt_s, ok_nxt_s, locked_nxt_s;
  logic [PIX_WIDTH-1:0] vtot_nxt_s, vact_nxt_s;

  // Single input register stage plus previous-value copies for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hs_r   <= 1'b0;
      vs_r   <= 1'b0;
      de_r   <= 1'b0;
      hs_d_r <= 1'b0;
      vs_d_r <= 1'b0;
    end else begin
      hs_r   <= vga_hs_i;
      vs_r   <= vga_vs_i;
      de_r   <= vga_de_i;
      hs_d_r <= hs_r;
      vs_d_r <= vs_r;
    end
  end

  // Leading edges and the per-line measurement; a vs edge also closes the line.
  always_comb begin
    hs_lead_s      = (hs_r == HS_ACT) && (hs_d_r != HS_ACT);
    vs_lead_s      = (vs_r == VS_ACT) && (vs_d_r != VS_ACT);
    line_evt_s     = hs_lead_s || vs_lead_s;
    h_total_s      = sat_inc(h_cnt_r);
    line_cnt_upd_s = sat_inc(line_cnt_r);
    line_bad_s     = (h_total_s != H_TOTAL_C) ||
                     ((de_cnt_r != ZERO_C) && (de_cnt_r != H_DISP_C));
    line_err_set_s = line_evt_s && line_bad_s && !skip_r && (state_r != SEARCH);
    if (de_cnt_r != ZERO_C) begin
      act_cnt_upd_s = sat_inc(act_cnt_r);
    end else begin
      act_cnt_upd_s = act_cnt_r;
    end
  end

  // Horizontal counters and the last-line measurement outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt_r         <= ZERO_C;
      de_cnt_r        <= ZERO_C;
      meas_h_total_o  <= ZERO_C;
      meas_h_active_o <= ZERO_C;
    end else if (line_evt_s) begin
      h_cnt_r         <= ZERO_C;
      de_cnt_r        <= ZERO_C;
      meas_h_total_o  <= h_total_s;
      meas_h_active_o <= de_cnt_r;
    end else begin
      h_cnt_r <= sat_inc(h_cnt_r);
      if (de_r) begin
        de_cnt_r <= sat_inc(de_cnt_r);
      end
    end
  end

  // Vertical counters; a vs edge snapshots the completed frame for evaluation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      line_cnt_r  <= ZERO_C;
      act_cnt_r   <= ZERO_C;
      line_err_r  <= 1'b0;
      pend_r      <= 1'b0;
      pend_lerr_r <= 1'b0;
      pend_vtot_r <= ZERO_C;
      pend_vact_r <= ZERO_C;
    end else if (vs_lead_s) begin
      line_cnt_r  <= ZERO_C;
      act_cnt_r   <= ZERO_C;
      line_err_r  <= 1'b0;
      pend_r      <= 1'b1;
      pend_lerr_r <= line_err_r || line_err_set_s;
      pend_vtot_r <= line_cnt_upd_s;
      pend_vact_r <= act_cnt_upd_s;
    end else begin
      pend_r <= 1'b0;
      if (hs_lead_s) begin
        line_cnt_r <= line_cnt_upd_s;
        act_cnt_r  <= act_cnt_upd_s;
        line_err_r <= line_err_r || line_err_set_s;
      end
    end
  end

  // The first line edge after (re)entering MEASURE only restarts counting.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      skip_r <= 1'b0;
    end else if (enter_meas_s) begin
      skip_r <= 1'b1;
    end else if (line_evt_s) begin
      skip_r <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= SEARCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state, driven by the frame evaluation one clock after the vs edge.
  always_comb begin
    frame_ok_s  = !pend_lerr_r && (pend_vtot_r == V_TOTAL_C) && (pend_vact_r == V_DISP_C);
    match_inc_s = match_cnt_r + 4'd1;
    state_nxt_s = state_r;
    case (state_r)
      SEARCH: begin
        if (pend_r) state_nxt_s = MEASURE;
        else        state_nxt_s = SEARCH;
      end
      MEASURE: begin
        if (pend_r && frame_ok_s && (match_inc_s >= LOCK_C)) state_nxt_s = LOCKED;
        else                                                  state_nxt_s = MEASURE;
      end
      LOCKED: begin
        if (pend_r && !frame_ok_s) state_nxt_s = MEASURE;
        else                       state_nxt_s = LOCKED;
      end
      default: state_nxt_s = SEARCH;
    endcase
    enter_meas_s = pend_r && (state_nxt_s == MEASURE) && (state_r != MEASURE);
  end

  // FSM outputs: next values of the registered frame results.
  always_comb begin
    done_nxt_s  = 1'b0;
    ok_nxt_s    = frame_ok_o;
    vtot_nxt_s  = meas_v_total_o;
    vact_nxt_s  = meas_v_active_o;
    match_nxt_s = match_cnt_r;
    err_nxt_s   = err_cnt_o;
    case (state_r)
      SEARCH: begin
        if (pend_r) match_nxt_s = 4'd0;
        else        match_nxt_s = match_cnt_r;
      end
      MEASURE: begin
        if (pend_r) begin
          done_nxt_s  = 1'b1;
          ok_nxt_s    = frame_ok_s;
          vtot_nxt_s  = pend_vtot_r;
          vact_nxt_s  = pend_vact_r;
          match_nxt_s = frame_ok_s ? match_inc_s : 4'd0;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      LOCKED: begin
        if (pend_r) begin
          done_nxt_s = 1'b1;
          ok_nxt_s   = frame_ok_s;
          vtot_nxt_s = pend_vtot_r;
          vact_nxt_s = pend_vact_r;
          if (!frame_ok_s) begin
            err_nxt_s   = (&err_cnt_o) ? err_cnt_o : err_cnt_o + 8'd1;
            match_nxt_s = 4'd0;
          end else begin
            match_nxt_s = match_cnt_r;
          end
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      default: begin
        done_nxt_s  = 1'b0;
        match_nxt_s = 4'd0;
      end
    endcase
    locked_nxt_s = (state_nxt_s == LOCKED);
  end

  // Registered frame results, lock flag and error counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_done_o    <= 1'b0;
      frame_ok_o      <= 1'b0;
      locked_o        <= 1'b0;
      err_cnt_o       <= 8'd0;
      meas_v_total_o  <= ZERO_C;
      meas_v_active_o <= ZERO_C;
      match_cnt_r     <= 4'd0;
    end else begin
      frame_done_o    <= done_nxt_s;
      frame_ok_o      <= ok_nxt_s;
      locked_o        <= locked_nxt_s;
      err_cnt_o       <= err_nxt_s;
      meas_v_total_o  <= vtot_nxt_s;
      meas_v_active_o <= vact_nxt_s;
      match_cnt_r     <= match_nxt_s;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [7:0]  r_r, g_r, b_r;
  logic [31:0] acc_r, pend_sum_r, pix_s;

  // Colour inputs share the single register stage with the sync inputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_r <= 8'd0;
      g_r <= 8'd0;
      b_r <= 8'd0;
    end else begin
      r_r <= vga_r_i;
      g_r <= vga_g_i;
      b_r <= vga_b_i;
    end
  end

  // Pixel contribution of the current clock.
  always_comb begin
    if (de_r) pix_s = {8'h00, r_r, g_r, b_r};
    else      pix_s = 32'h0000_0000;
  end

  // Accumulate pixels; the vs edge snapshots the sum including its own pixel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_r      <= 32'h0000_0000;
      pend_sum_r <= 32'h0000_0000;
    end else if (vs_lead_s) begin
      acc_r      <= 32'h0000_0000;
      pend_sum_r <= acc_r + pix_s;
    end else begin
      acc_r <= acc_r + pix_s;
    end
  end

  // Publish the checksum together with frame_done_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_sum_o <= 32'h0000_0000;
    end else if (done_nxt_s) begin
      frame_sum_o <= pend_sum_r;
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb  = ^{vga_r_i, vga_g_i, vga_b_i};
  assign frame_sum_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Self-checking bench for vga_rx_monitor with a small test mode
// (24 clocks/line, 16 active pixels, 7 lines/frame, 4 active lines).
// Expected frame results are pushed when a vs edge is driven and popped
// when frame_done_o pulses.
`timescale 1ns/1ps
module tb_vga_rx_monitor;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hs, vs, de;
  logic [7:0]    r, g, b;
  logic [PW-1:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
  logic          frame_done, frame_ok, locked;
  logic [7:0]    err_cnt;
  logic [31:0]   frame_sum;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .PIX_WIDTH(PW), .H_DISP(16), .H_TOTAL(24), .V_DISP(4), .V_TOTAL(7),
    .HS_POL(0), .VS_POL(0), .LOCK_FRAMES(2)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .vga_hs_i(hs), .vga_vs_i(vs), .vga_de_i(de),
    .vga_r_i(r), .vga_g_i(g), .vga_b_i(b),
    .meas_h_total_o(meas_h_total), .meas_h_active_o(meas_h_active),
    .meas_v_total_o(meas_v_total), .meas_v_active_o(meas_v_active),
    .frame_done_o(frame_done), .frame_ok_o(frame_ok), .locked_o(locked),
    .err_cnt_o(err_cnt), .frame_sum_o(frame_sum)
  );

  typedef struct {
    int          h_total, h_active, v_total, v_active;
    logic        ok, locked;
    int          err;
    logic [31:0] sum;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        got_e;
  int          vectors = 0, miscompares = 0, pulses = 0, pushes = 0;
  int          m_state = 0, m_match = 0, m_err = 0;
  int          cur_lines = 0, cur_act = 0, cur_hact = 0, pulses_at_rst = 0;
  bit          cur_bad = 1'b0;
  logic [31:0] cur_sum = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_h_total"},  32'(meas_h_total),  32'd0);
    check({tag, "_h_active"}, 32'(meas_h_active), 32'd0);
    check({tag, "_v_total"},  32'(meas_v_total),  32'd0);
    check({tag, "_v_active"}, 32'(meas_v_active), 32'd0);
    check({tag, "_done"},     32'(frame_done),    32'd0);
    check({tag, "_ok"},       32'(frame_ok),      32'd0);
    check({tag, "_locked"},   32'(locked),        32'd0);
    check({tag, "_err"},      32'(err_cnt),       32'd0);
    check({tag, "_sum"},      frame_sum,          32'd0);
  endtask

  // Scoreboard: compare every frame_done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_done === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("h_total",  32'(meas_h_total),  32'(got_e.h_total));
        check("h_active", 32'(meas_h_active), 32'(got_e.h_active));
        check("v_total",  32'(meas_v_total),  32'(got_e.v_total));
        check("v_active", 32'(meas_v_active), 32'(got_e.v_active));
        check("frame_ok", 32'(frame_ok),      32'(got_e.ok));
        check("locked",   32'(locked),        32'(got_e.locked));
        check("err_cnt",  32'(err_cnt),       32'(got_e.err));
        check("frame_sum", frame_sum,         got_e.sum);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the frame evaluation at a vs leading edge.
  task automatic frame_end();
    exp_t e;
    bit   ok;
    if (m_state == 0) begin
      m_state = 1;
      m_match = 0;
    end else begin
      ok = !cur_bad && (cur_lines == 7) && (cur_act == 4);
      if (m_state == 1) begin
        if (ok) begin
          m_match++;
          if (m_match >= 2) m_state = 2;
        end else begin
          m_match = 0;
        end
      end else if (!ok) begin
        if (m_err < 255) m_err++;
        m_match = 0;
        m_state = 1;
      end
      e.h_total  = 24;
      e.h_active = cur_hact;
      e.v_total  = cur_lines;
      e.v_active = cur_act;
      e.ok       = ok;
      e.locked   = (m_state == 2);
      e.err      = m_err;
`ifdef VGA_RX_CHECKSUM_EN
      e.sum      = cur_sum;
`else
      e.sum      = 32'h0;
`endif
      exp_q.push_back(e);
      pushes++;
    end
    cur_sum = 32'h0;
  endtask

  // One frame: vs and hs lead together at line 0; active lines are the last four.
  task automatic send_frame(input int nlines, input int short_line, input int rst_line);
    int nde;
    for (int ln = 0; ln < nlines; ln++) begin
      for (int c = 0; c < 24; c++) begin
        nde = (ln == short_line) ? 15 : 16;
        hs  = (c < 2) ? 1'b0 : 1'b1;
        vs  = (ln < 2) ? 1'b0 : 1'b1;
        de  = (ln >= nlines - 4) && (c >= 4) && (c < 4 + nde);
        r   = 8'h01;
        g   = 8'h02;
        b   = 8'h03;
        if (ln == 0 && c == 0) begin
          frame_end();
          cur_lines = nlines;
          cur_act   = 4;
          cur_bad   = (short_line >= 0);
          cur_hact  = (short_line == nlines - 1) ? 15 : 16;
        end
        if (de) cur_sum = cur_sum + 32'h0001_0203;
        if (ln == rst_line && c == 10) begin
          pulses_at_rst = pulses;
          rst_n = 1'b0;
          #1;
          check_zero("rst_mid");
          tick();
          rst_n   = 1'b1;
          m_state = 0;
          m_match = 0;
          m_err   = 0;
        end else begin
          tick();
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hs = 1'b1; vs = 1'b1; de = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    repeat (5) tick();

    // Ideal timing: three evaluated frames, lock on the second.
    repeat (4) send_frame(7, -1, -1);
    check("s1_pulses", 32'(pulses), 32'd3);
    check("s1_locked", 32'(locked), 32'd1);
    check("s1_err",    32'(err_cnt), 32'd0);

    // One frame with a 15-pixel line while locked, then relock.
    send_frame(7, 4, -1);
    repeat (3) send_frame(7, -1, -1);
    check("s2_locked", 32'(locked), 32'd1);
    check("s2_err",    32'(err_cnt), 32'd1);

    // Eight-line frames never match.
    repeat (3) send_frame(8, -1, -1);
    check("s3_locked",   32'(locked),       32'd0);
    check("s3_v_total",  32'(meas_v_total), 32'd8);

    // Relock, then a one-cycle reset mid-frame.
    repeat (3) send_frame(7, -1, -1);
    check("s5_locked_before", 32'(locked), 32'd1);
    send_frame(7, -1, 3);
    send_frame(7, -1, -1);
    check("s5_no_pulse_after_rst", 32'(pulses), 32'(pulses_at_rst));
    send_frame(7, -1, -1);
    check("s5_locked_after", 32'(locked), 32'd0);
    send_frame(7, -1, -1);
    hs = 1'b1; vs = 1'b1; de = 1'b0;
    repeat (10) tick();
    check("final_locked",  32'(locked),  32'd1);
    check("final_err",     32'(err_cnt), 32'd0);
    check("sb_drained",    32'(exp_q.size()), 32'd0);
    check("sb_pulse_count", 32'(pulses), 32'(pushes));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side monitor for the VGA pixel interface driven by the Tetris renderer: hs, vs, de and 24-bit RGB.
- Measures line and frame timing and checks it against expected mode parameters.
- Declares lock after consecutive good frames and counts timing errors.
- Used in simulation benches and on-chip next to the video output for debug readout.

Parameters:
- PIX_WIDTH, 12, width of all timing counters and measured values.
- H_DISP, 1280, expected de-high pixels per active line.
- H_TOTAL, 1688, expected clocks between hs leading edges.
- V_DISP, 1024, expected lines containing de per frame.
- V_TOTAL, 1066, expected lines between vs leading edges.
- HS_POL, 0, active level of hs (0 = active-low).
- VS_POL, 0, active level of vs (0 = active-low).
- LOCK_FRAMES, 2, consecutive matching frames required for lock (1..15).

Ports:
- clk_i  in  1  pixel clock.
- rst_n_i  in  1  asynchronous active-low reset.
- vga_hs_i  in  1  horizontal sync.
- vga_vs_i  in  1  vertical sync.
- vga_de_i  in  1  data enable.
- vga_r_i / vga_g_i / vga_b_i  in  8 each  pixel colour.
- meas_h_total_o  out  PIX_WIDTH  last measured clocks per line.
- meas_h_active_o  out  PIX_WIDTH  de count of last line.
- meas_v_total_o  out  PIX_WIDTH  lines in last frame.
- meas_v_active_o  out  PIX_WIDTH  lines with de in last frame.
- frame_done_o  out  1  one-cycle pulse when frame results update.
- frame_ok_o  out  1  last frame matched all expectations.
- locked_o  out  1  lock state.
- err_cnt_o  out  8  saturating count of failed frames while LOCKED.
- frame_sum_o  out  32  frame pixel checksum (optional feature).

Behaviour:
- Reset: clock is clk_i; reset is asynchronous, active-low (rst_n_i). All outputs, counters and input registers go to 0; state goes to SEARCH.
- Input stage: all inputs are registered once. Leading edge = registered sync at its active level while the previous registered value was inactive. All logic below runs on the registered values.
- Horizontal:
  - h_cnt clears to 0 on an hs leading edge and increments every clock, saturating at all-ones.
  - de_cnt increments on each de-high clock, saturating.
  - On an hs leading edge: meas_h_total_o <= h_cnt+1 (saturating) and meas_h_active_o <= de_cnt; de_cnt clears.
  - The line is bad if h_total != H_TOTAL, or de_cnt is neither 0 nor H_DISP. A bad line sets sticky line_err.
  - The first hs edge after entering MEASURE only starts counting and is not checked.
- Vertical:
  - line_cnt increments on each hs leading edge.
  - act_cnt increments on hs leading edges whose completed line had de_cnt>0.
  - A line in progress at the vs leading edge is counted and checked as if an hs edge occurred in the same cycle.
- Frame end (vs leading edge, MEASURE or LOCKED):
  - Latch meas_v_total_o/meas_v_active_o.
  - frame_ok = !line_err && v_total==V_TOTAL && v_active==V_DISP.
  - Pulse frame_done_o with frame_ok_o valid, 2 clocks after the clock edge that first samples vs active.
  - Clear line_cnt, act_cnt and line_err.
- FSM:
  - SEARCH: wait for the first vs leading edge, then go to MEASURE with match_cnt=0. The partial frame is discarded and frame_done_o is not pulsed.
  - MEASURE, frame ok: match_cnt++. When match_cnt reaches LOCK_FRAMES, go to LOCKED and set locked_o.
  - MEASURE, frame bad: match_cnt=0 and stay in MEASURE.
  - LOCKED, frame bad: locked_o=0, err_cnt_o++ (saturates at 255), match_cnt=0, go to MEASURE. err_cnt_o clears only on reset.
- Simultaneous hs and vs leading edges: the line completes first, then the frame evaluates using the updated counts.
- Missing vs: line_cnt saturates at all-ones, which guarantees a mismatch at the next vs.
- Reset mid-frame: returns to SEARCH, and the next full frame is measured from scratch.

Optional Feature:
- Macro VGA_RX_CHECKSUM_EN.
- Defined:
  - 32-bit accumulator adds {8'h0,r,g,b} on every de-high clock, modulo 2^32.
  - On a vs leading edge: frame_sum_o <= accumulator including that cycle's pixel if de, and the accumulator clears.
  - Updates together with frame_done_o.
- Undefined: frame_sum_o is tied to 0 and no accumulator exists.

Test Plan:
Parameters for all scenarios: H_DISP=16, H_TOTAL=24, V_DISP=4, V_TOTAL=7, LOCK_FRAMES=2.
- Ideal timing, 4 frames -> 3 frame_done_o pulses with h_total=24, h_active=16, v_total=7, v_active=4, frame_ok_o=1; locked_o rises with the 2nd pulse; err_cnt_o=0.
- Lock, then one frame with a line of 15 de pixels -> frame_ok_o=0, locked_o falls, err_cnt_o=1; two good frames later locked_o=1 again.
- V_TOTAL=8 lines supplied -> meas_v_total_o=8, frame_ok_o=0, lock never asserted.
- hs and vs leading edges in the same cycle -> line counted, v_total=7, frame_ok_o=1.
- rst_n_i low for 1 cycle mid-frame while LOCKED -> all outputs 0 immediately; first frame_done_o comes only after a full frame following the next vs edge.
- With VGA_RX_CHECKSUM_EN and all pixels 24'h010203 -> frame_sum_o=64*24'h010203=32'h0040_80C0; without the macro, frame_sum_o=0.
